// File: rtl/fme_ref_loader_pkg.sv
// Shared parameters and types for the FME reference-pixel loader slice.
package fme_ref_loader_pkg;

   localparam int FME_PIX_NUM   = 20;
   localparam int FME_BIT_DEPTH = 8;
   localparam int FME_ROW_W     = 5;
   localparam int FME_BLK_W     = 2;
   localparam int FME_MARGIN_Y  = 3;
   localparam int FME_MARGIN_C  = 1;
   localparam int FME_DATA_W    = FME_PIX_NUM * FME_BIT_DEPTH;
   localparam int FME_TAG_W     = 3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic coloc;
      logic blk_end;
      logic part_end;
   } tag_t;

endpackage

// File: rtl/fme_ref_loader_if.sv
// Command, RAM-read and reference-row stream signals of the FME reference loader.
interface fme_ref_loader_if #(
   parameter int ROW_W  = 5,
   parameter int BLK_W  = 2,
   parameter int DATA_W = 160
);
   logic              cmd_vld_i;
   logic              cmd_rdy_o;
   logic [ROW_W-1:0]  cmd_rows_i;
   logic [BLK_W-1:0]  cmd_blks_i;
   logic              cmd_chroma_i;
   logic              abort_i;
   logic              empty_i;
   logic              rden_o;
   logic [DATA_W-1:0] rddata_i;
   logic              ref_vld_o;
   logic              ref_rdy_i;
   logic [DATA_W-1:0] ref_data_o;
   logic              ref_coloc_o;
   logic              ref_blk_end_o;
   logic              ref_part_end_o;
   logic              end_rd_o;

   modport slave (
      input  cmd_vld_i, cmd_rows_i, cmd_blks_i, cmd_chroma_i, abort_i,
      input  empty_i, rddata_i, ref_rdy_i,
      output cmd_rdy_o, rden_o, ref_vld_o, ref_data_o,
      output ref_coloc_o, ref_blk_end_o, ref_part_end_o, end_rd_o
   );

   modport master (
      output cmd_vld_i, cmd_rows_i, cmd_blks_i, cmd_chroma_i, abort_i,
      output empty_i, rddata_i, ref_rdy_i,
      input  cmd_rdy_o, rden_o, ref_vld_o, ref_data_o,
      input  ref_coloc_o, ref_blk_end_o, ref_part_end_o, end_rd_o
   );
endinterface

// File: rtl/fme_ref_loader_skid.sv
// Two-entry skid FIFO holding returned rows plus tags; the head register drives the stream.
module fme_ref_loader_skid #(
   parameter int W = 163
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] head_o,
   output logic         vld_o,
   output logic [1:0]   occ_o
);
   logic [W-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]   occ_q, occ_d;
   logic         pop_s;

   assign pop_s = pop_i & (occ_q != 2'd0);

   // Next occupancy and entry contents; order is kept by always shifting tail into head
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush_i) begin
         occ_d = 2'd0;
      end else begin
         case ({push_i, pop_s})
            2'b10: begin
               if (occ_q == 2'd0) begin
                  head_d = din_i;
                  occ_d  = 2'd1;
               end else if (occ_q == 2'd1) begin
                  tail_d = din_i;
                  occ_d  = 2'd2;
               end else begin
                  occ_d  = occ_q;
               end
            end
            2'b01: begin
               occ_d = occ_q - 2'd1;
               if (occ_q == 2'd2) begin
                  head_d = tail_q;
               end else begin
                  head_d = head_q;
               end
            end
            2'b11: begin
               if (occ_q == 2'd2) begin
                  head_d = tail_q;
                  tail_d = din_i;
               end else begin
                  head_d = din_i;
               end
            end
            default: occ_d = occ_q;
         endcase
      end
   end

   // Entry and occupancy registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign head_o = head_q;
   assign vld_o  = (occ_q != 2'd0);
   assign occ_o  = occ_q;

endmodule

// File: rtl/fme_ref_loader.sv
// FME reference-pixel loader: command-driven RAM reader with credit-limited skid
// buffer, co-located / end-of-block sideband tags and synchronous abort.
module fme_ref_loader
   import fme_ref_loader_pkg::*;
#(
   parameter int PIX_NUM   = FME_PIX_NUM,
   parameter int BIT_DEPTH = FME_BIT_DEPTH,
   parameter int ROW_W     = FME_ROW_W,
   parameter int BLK_W     = FME_BLK_W,
   parameter int MARGIN_Y  = FME_MARGIN_Y,
   parameter int MARGIN_C  = FME_MARGIN_C
) (
   input logic              clk_i,
   input logic              rst_n_i,
   fme_ref_loader_if.slave  bus
);
   localparam int DATA_W = PIX_NUM * BIT_DEPTH;
   localparam int SKID_W = DATA_W + FME_TAG_W;
   localparam logic [ROW_W:0] MRG_Y = MARGIN_Y[ROW_W:0];
   localparam logic [ROW_W:0] MRG_C = MARGIN_C[ROW_W:0];

   state_e            state_q, state_d;
   logic [ROW_W-1:0]  row_cn_q, row_cn_d, rows_q, rows_d;
   logic [BLK_W-1:0]  blk_cn_q, blk_cn_d, blks_q, blks_d;
   logic              chroma_q, chroma_d, inflight_q, inflight_d;
   tag_t              tag_q, tag_d;

   logic              run_s, row_last_s, blk_last_s, credit_ok_s;
   logic              rden_s, last_rd_s, cmd_rdy_s, accept_s, coloc_s;
   logic              pop_s, push_s, skid_vld_s;
   logic [1:0]        occ_s;
   logic [2:0]        occ_eff_s;
   logic [ROW_W:0]    margin_s, row_e_s, rows_e_s;
   logic [SKID_W-1:0] skid_din_s, skid_head_s;
   tag_t              head_tag_s;

   assign run_s      = (state_q == ST_RUN);
   assign row_last_s = (row_cn_q == rows_q);
   assign blk_last_s = (blk_cn_q == blks_q);

   // An entry popped this cycle is free for the read issued now, allowing 1 row/cycle
   assign occ_eff_s   = {1'b0, occ_s} - {2'b00, pop_s};
   assign credit_ok_s = ((occ_eff_s + {2'b00, inflight_q}) < 3'd2);

   assign rden_s    = run_s & ~bus.empty_i & credit_ok_s & ~bus.abort_i;
   assign last_rd_s = rden_s & row_last_s & blk_last_s;
   assign cmd_rdy_s = ~run_s | last_rd_s;
   assign accept_s  = bus.cmd_vld_i & cmd_rdy_s & ~bus.abort_i;

   // One extra bit so row+margin cannot wrap and small blocks never look co-located
   assign margin_s = chroma_q ? MRG_C : MRG_Y;
   assign row_e_s  = {1'b0, row_cn_q};
   assign rows_e_s = {1'b0, rows_q};
   assign coloc_s  = (row_e_s >= margin_s) && ((row_e_s + margin_s) <= rows_e_s);

   // Next-state: FSM, row/blk counters, command latch and read-aligned tags
   always_comb begin
      state_d    = state_q;
      row_cn_d   = row_cn_q;
      blk_cn_d   = blk_cn_q;
      rows_d     = rows_q;
      blks_d     = blks_q;
      chroma_d   = chroma_q;
      inflight_d = rden_s;
      tag_d      = tag_q;

      if (rden_s) begin
         tag_d.coloc    = coloc_s;
         tag_d.blk_end  = row_last_s;
         tag_d.part_end = last_rd_s;
         if (row_last_s) begin
            row_cn_d = '0;
            blk_cn_d = blk_last_s ? '0 : (blk_cn_q + BLK_W'(1));
         end else begin
            row_cn_d = row_cn_q + ROW_W'(1);
         end
      end else begin
         tag_d = tag_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_rd_s && !accept_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept_s) begin
         rows_d   = bus.cmd_rows_i;
         blks_d   = bus.cmd_blks_i;
         chroma_d = bus.cmd_chroma_i;
         row_cn_d = '0;
         blk_cn_d = '0;
      end else begin
         rows_d = rows_q;
      end

      if (bus.abort_i) begin
         state_d    = ST_IDLE;
         row_cn_d   = '0;
         blk_cn_d   = '0;
         inflight_d = 1'b0;
         tag_d      = '0;
      end else begin
         inflight_d = rden_s;
      end
   end

   // State, counters, latched command and tag pipeline registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         row_cn_q   <= '0;
         blk_cn_q   <= '0;
         rows_q     <= '0;
         blks_q     <= '0;
         chroma_q   <= 1'b0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
      end else begin
         state_q    <= state_d;
         row_cn_q   <= row_cn_d;
         blk_cn_q   <= blk_cn_d;
         rows_q     <= rows_d;
         blks_q     <= blks_d;
         chroma_q   <= chroma_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
      end
   end

   // Data of a read issued just before an abort is dropped here
   assign push_s     = inflight_q & ~bus.abort_i;
   assign skid_din_s = {tag_q, bus.rddata_i};
   assign pop_s      = skid_vld_s & bus.ref_rdy_i;

   fme_ref_loader_skid #(.W(SKID_W)) u_skid (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .flush_i (bus.abort_i),
      .din_i   (skid_din_s),
      .head_o  (skid_head_s),
      .vld_o   (skid_vld_s),
      .occ_o   (occ_s)
   );

   assign head_tag_s         = tag_t'(skid_head_s[DATA_W +: FME_TAG_W]);
   assign bus.ref_vld_o      = skid_vld_s;
   assign bus.ref_data_o     = skid_head_s[DATA_W-1:0];
   assign bus.ref_coloc_o    = head_tag_s.coloc;
   assign bus.ref_blk_end_o  = head_tag_s.blk_end;
   assign bus.ref_part_end_o = head_tag_s.part_end;
   assign bus.rden_o         = rden_s;
   assign bus.end_rd_o       = last_rd_s;
   assign bus.cmd_rdy_o      = cmd_rdy_s;

endmodule

// File: tb/tb_fme_ref_loader.sv
// Directed bench for fme_ref_loader: RAM model, expected-row scoreboard and hand-counted tag totals.
module tb_fme_ref_loader;
   import fme_ref_loader_pkg::*;

   localparam int CW = 192;

   typedef struct packed {
      logic [FME_DATA_W-1:0] data;
      logic [2:0]            tags;
   } ent_t;

   typedef struct packed {
      logic [FME_ROW_W-1:0] rows;
      logic [FME_BLK_W-1:0] blks;
      logic                 chroma;
   } cmd_t;

   logic clk_i   = 1'b0;
   logic rst_n_i = 1'b0;
   always #5 clk_i = ~clk_i;

   fme_ref_loader_if #(.ROW_W(FME_ROW_W), .BLK_W(FME_BLK_W), .DATA_W(FME_DATA_W)) bus ();

   fme_ref_loader dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (bus.slave)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   ent_t mq[$];
   logic [2:0] exp_q[$];
   cmd_t cmd_list[$];
   logic rdy_v = 1'b1, abort_v = 1'b0, rnd_mode = 1'b0, pend = 1'b0;
   int   pend_idx = 0, rd_idx = 0, cyc = 0;
   int   n_rden, n_out, n_coloc, n_blk_end, n_part_end, n_end_rd, n_acc;
   int   first_rden, last_rden, first_vld;

   task automatic check_val(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FME_DATA_W-1:0] pix(input int n);
      logic [FME_DATA_W-1:0] d;
      d = '0;
      for (int i = 0; i < FME_PIX_NUM; i++) d[i*FME_BIT_DEPTH +: FME_BIT_DEPTH] = FME_BIT_DEPTH'(n * 7 + i);
      return d;
   endfunction

   task automatic clr_stats();
      n_rden = 0; n_out = 0; n_coloc = 0; n_blk_end = 0; n_part_end = 0; n_end_rd = 0; n_acc = 0;
      first_rden = -1; last_rden = -1; first_vld = -1;
   endtask

   task automatic push_cmd(input int rows, input int blks, input logic chroma);
      cmd_t c;
      c.rows = FME_ROW_W'(rows); c.blks = FME_BLK_W'(blks); c.chroma = chroma;
      cmd_list.push_back(c);
   endtask

   // Expected tag sequence of an accepted command: {coloc, blk_end, part_end} per row
   task automatic add_cmd_rows(input cmd_t c);
      int m;
      logic [2:0] t;
      m = c.chroma ? FME_MARGIN_C : FME_MARGIN_Y;
      for (int b = 0; b <= int'(c.blks); b++) begin
         for (int r = 0; r <= int'(c.rows); r++) begin
            t[2] = (r >= m) && (r + m <= int'(c.rows));
            t[1] = (r == int'(c.rows));
            t[0] = (b == int'(c.blks)) && t[1];
            exp_q.push_back(t);
         end
      end
   endtask

   // One clock: drive inputs at the falling edge, observe 1 ns later, then wait for the next falling edge
   task automatic tick();
      logic pop, exp_end;
      int   qs;
      ent_t e;
      logic [2:0] t;
      bus.cmd_vld_i = (cmd_list.size() != 0);
      if (cmd_list.size() != 0) begin
         bus.cmd_rows_i   = cmd_list[0].rows;
         bus.cmd_blks_i   = cmd_list[0].blks;
         bus.cmd_chroma_i = cmd_list[0].chroma;
      end
      bus.abort_i   = abort_v;
      bus.empty_i   = rnd_mode ? ($urandom_range(0, 3) == 32'd0) : 1'b0;
      bus.ref_rdy_i = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_v;
      bus.rddata_i  = pend ? pix(pend_idx) : '0;
      #1;
      qs  = mq.size();
      pop = bus.ref_vld_o & bus.ref_rdy_i;
      if (bus.ref_vld_o && first_vld < 0) first_vld = cyc;
      if (pop) begin
         n_out++;
         n_coloc    += int'(bus.ref_coloc_o);
         n_blk_end  += int'(bus.ref_blk_end_o);
         n_part_end += int'(bus.ref_part_end_o);
         if (mq.size() == 0) begin
            check_val("vld_without_row", CW'(1'b1), CW'(1'b0));
         end else begin
            e = mq.pop_front();
            check_val("row_data", CW'(bus.ref_data_o), CW'(e.data));
            check_val("row_tags", CW'({bus.ref_coloc_o, bus.ref_blk_end_o, bus.ref_part_end_o}), CW'(e.tags));
         end
      end
      exp_end = 1'b0;
      if (bus.rden_o) begin
         n_rden++;
         if (first_rden < 0) first_rden = cyc;
         last_rden = cyc;
         check_val("credit", CW'((qs - int'(pop)) < 2), CW'(1'b1));
         check_val("rden_when_empty", CW'(bus.empty_i), CW'(1'b0));
         if (exp_q.size() == 0) begin
            check_val("rden_extra", CW'(1'b1), CW'(1'b0));
         end else begin
            t       = exp_q.pop_front();
            exp_end = t[0];
            e.data  = pix(rd_idx);
            e.tags  = t;
            mq.push_back(e);
         end
         pend = 1'b1; pend_idx = rd_idx; rd_idx++;
      end else begin
         pend = 1'b0;
      end
      check_val("end_rd", CW'(bus.end_rd_o), CW'(exp_end));
      n_end_rd += int'(bus.end_rd_o);
      if (bus.cmd_vld_i && bus.cmd_rdy_o && !abort_v) begin
         add_cmd_rows(cmd_list.pop_front());
         n_acc++;
      end
      if (abort_v) begin
         mq.delete(); exp_q.delete(); pend = 1'b0;
      end
      cyc++;
      @(negedge clk_i);
   endtask

   task automatic run_until_done(input string tag, input int max_cyc);
      int n;
      n = 0;
      while ((cmd_list.size() != 0 || exp_q.size() != 0 || mq.size() != 0) && n < max_cyc) begin
         tick(); n++;
      end
      check_val(tag, CW'(n < max_cyc), CW'(1'b1));
      repeat (3) tick();
   endtask

   // Abort with the skid full (hold_full=1) or with a read in flight (hold_full=0), then recover
   task automatic run_abort(input logic hold_full);
      int n;
      clr_stats();
      rdy_v = 1'b1;
      push_cmd(9, 0, 1'b0);
      n = 0;
      while (n_rden < 5 && n < 50) begin tick(); n++; end
      check_val("abort_reach_row5", CW'(n < 50), CW'(1'b1));
      if (hold_full) begin
         rdy_v = 1'b0;
         repeat (4) tick();
         check_val("abort_pre_vld", CW'(bus.ref_vld_o), CW'(1'b1));
      end
      abort_v = 1'b1;
      tick();
      abort_v = 1'b0;
      check_val("abort_vld", CW'(bus.ref_vld_o), CW'(1'b0));
      check_val("abort_cmd_rdy", CW'(bus.cmd_rdy_o), CW'(1'b1));
      check_val("abort_rden", CW'(bus.rden_o), CW'(1'b0));
      check_val("abort_no_end_rd", CW'(n_end_rd), CW'(0));
      check_val("abort_no_part_end", CW'(n_part_end), CW'(0));
      rdy_v = 1'b1;
      clr_stats();
      push_cmd(1, 0, 1'b0);
      run_until_done("abort_recover_done", 50);
      check_val("abort_recover_rows", CW'(n_out), CW'(2));
      check_val("abort_recover_end_rd", CW'(n_end_rd), CW'(1));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cmd_vld_i = 1'b0; bus.cmd_rows_i = '0; bus.cmd_blks_i = '0; bus.cmd_chroma_i = 1'b0;
      bus.abort_i = 1'b0; bus.empty_i = 1'b1; bus.ref_rdy_i = 1'b0; bus.rddata_i = '0;
      clr_stats();
      repeat (3) @(negedge clk_i);
      check_val("rst_cmd_rdy", CW'(bus.cmd_rdy_o), CW'(1'b1));
      check_val("rst_ref_vld", CW'(bus.ref_vld_o), CW'(1'b0));
      rst_n_i = 1'b1;
      @(negedge clk_i);
      check_val("post_rst_rden", CW'(bus.rden_o), CW'(1'b0));
      check_val("post_rst_end_rd", CW'(bus.end_rd_o), CW'(1'b0));
      check_val("post_rst_data", CW'(bus.ref_data_o), CW'(0));

      // rows=9 luma: 10 rows, coloc on 3..6, one end of block/subpart, 2-cycle rden->valid
      clr_stats();
      push_cmd(9, 0, 1'b0);
      run_until_done("t1_done", 100);
      check_val("t1_rden", CW'(n_rden), CW'(10));
      check_val("t1_out", CW'(n_out), CW'(10));
      check_val("t1_coloc", CW'(n_coloc), CW'(4));
      check_val("t1_blk_end", CW'(n_blk_end), CW'(1));
      check_val("t1_part_end", CW'(n_part_end), CW'(1));
      check_val("t1_end_rd", CW'(n_end_rd), CW'(1));
      check_val("t1_latency", CW'(first_vld - first_rden), CW'(2));
      check_val("t1_streaming", CW'(last_rden - first_rden), CW'(9));

      // rows=4 blks=3 chroma: 20 rows, coloc rows 1..3 of each block
      clr_stats();
      push_cmd(4, 3, 1'b1);
      run_until_done("t2_done", 200);
      check_val("t2_out", CW'(n_out), CW'(20));
      check_val("t2_blk_end", CW'(n_blk_end), CW'(4));
      check_val("t2_part_end", CW'(n_part_end), CW'(1));
      check_val("t2_coloc", CW'(n_coloc), CW'(12));
      check_val("t2_end_rd", CW'(n_end_rd), CW'(1));

      // rows=3 luma: block too small for the 6-tap margin
      clr_stats();
      push_cmd(3, 0, 1'b0);
      run_until_done("t3_done", 100);
      check_val("t3_out", CW'(n_out), CW'(4));
      check_val("t3_coloc", CW'(n_coloc), CW'(0));

      // Random backpressure and RAM empty
      clr_stats();
      rnd_mode = 1'b1;
      push_cmd(7, 1, 1'b0);
      push_cmd(5, 2, 1'b1);
      run_until_done("t4_done", 3000);
      rnd_mode = 1'b0;
      check_val("t4_out", CW'(n_out), CW'(34));
      check_val("t4_blk_end", CW'(n_blk_end), CW'(5));
      check_val("t4_part_end", CW'(n_part_end), CW'(2));
      check_val("t4_coloc", CW'(n_coloc), CW'(4 + 12));

      // Back-to-back commands with cmd_vld held: no idle read cycle between subparts
      clr_stats();
      rdy_v = 1'b1;
      push_cmd(2, 1, 1'b0);
      push_cmd(1, 2, 1'b1);
      run_until_done("t5_done", 200);
      check_val("t5_accepts", CW'(n_acc), CW'(2));
      check_val("t5_rden", CW'(n_rden), CW'(12));
      check_val("t5_no_gap", CW'(last_rden - first_rden + 1), CW'(12));
      check_val("t5_end_rd", CW'(n_end_rd), CW'(2));

      run_abort(1'b1);
      run_abort(1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
